// File: rtl/midi_floppy_ctrl_if.sv
// rtl/midi_floppy_ctrl_if.sv - serial byte input and note-state output bundle for midi_floppy_ctrl
interface midi_floppy_ctrl_if;
   logic [7:0]  rx_data;
   logic        new_rx_data;
   logic        f_en;
   logic [21:0] f_sp;
   logic [6:0]  note;
   logic        evt;

   modport master (
      output rx_data, new_rx_data,
      input  f_en, f_sp, note, evt
   );

   modport slave (
      input  rx_data, new_rx_data,
      output f_en, f_sp, note, evt
   );
endinterface

// File: rtl/midi_floppy_ctrl.sv
// rtl/midi_floppy_ctrl.sv - MIDI channel-message parser driving a monophonic floppy step setpoint
module midi_floppy_ctrl #(
   parameter logic [3:0] CHANNEL  = 4'd0,
   parameter logic [6:0] NOTE_MIN = 7'd24,
   parameter logic [6:0] NOTE_MAX = 7'd84
) (
   input  logic               clk,
   input  logic               rst_n,
   midi_floppy_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

   state_t     state, state_nx;
   logic [3:0] rs_type, rs_type_nx;
   logic       rs_match, rs_match_nx;
   logic [6:0] d1_q, d1_nx;
   logic [7:0] byte_in;

   logic       msg_done;
   logic [6:0] msg_d1, msg_d2;

   logic       dec_on, dec_off, dec_alloff;
   logic [3:0] oct, semi;

   logic       s1_on, s1_off, s1_alloff;
   logic [6:0] s1_note;
   logic [3:0] s1_semi, s1_oct;

   logic       f_en_q, evt_q;
   logic [21:0] f_sp_q;
   logic [6:0] note_q;

   assign byte_in = bus.rx_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rs_type  <= 4'd0;
         rs_match <= 1'b0;
         d1_q     <= 7'd0;
      end else begin
         state    <= state_nx;
         rs_type  <= rs_type_nx;
         rs_match <= rs_match_nx;
         d1_q     <= d1_nx;
      end
   end

   // Realtime bytes (F8-FF) fall through untouched so they can sit inside a message.
   always_comb begin
      state_nx    = state;
      rs_type_nx  = rs_type;
      rs_match_nx = rs_match;
      d1_nx       = d1_q;
      msg_done    = 1'b0;
      msg_d1      = d1_q;
      msg_d2      = 7'd0;
      if (bus.new_rx_data && (byte_in < 8'hF8)) begin
         if (byte_in >= 8'hF0) begin
            state_nx = IDLE;
         end else if (byte_in[7]) begin
            rs_type_nx  = byte_in[7:4];
            rs_match_nx = (byte_in[3:0] == CHANNEL);
            state_nx    = WAIT_D1;
         end else begin
            case (state)
               WAIT_D1: begin
                  if (rs_type == 4'hC || rs_type == 4'hD) begin
                     msg_done = 1'b1;
                     msg_d1   = byte_in[6:0];
                  end else begin
                     d1_nx    = byte_in[6:0];
                     state_nx = WAIT_D2;
                  end
               end
               WAIT_D2: begin
                  msg_done = 1'b1;
                  msg_d2   = byte_in[6:0];
                  state_nx = WAIT_D1;
               end
               default: begin
                  state_nx = state;
               end
            endcase
         end
      end
   end

   always_comb begin
      dec_on     = 1'b0;
      dec_off    = 1'b0;
      dec_alloff = 1'b0;
      if (msg_done && rs_match) begin
         case (rs_type)
            4'h9: begin
               if (msg_d2 != 7'd0)
                  dec_on = (msg_d1 >= NOTE_MIN) && (msg_d1 <= NOTE_MAX);
               else
                  dec_off = 1'b1;
            end
            4'h8: dec_off = 1'b1;
            4'hB: dec_alloff = (msg_d1 == 7'd123) || (msg_d1 == 7'd120);
            default: dec_on = 1'b0;
         endcase
      end
   end

   // Octave and semitone of the note via a compare chain rather than a divider.
   always_comb begin
      oct = 4'd0;
      for (int i = 1; i <= 10; i++) begin
         if (int'(msg_d1) >= 12 * i)
            oct = 4'(i);
      end
      semi = 4'(msg_d1 - 7'(oct * 12));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_on     <= 1'b0;
         s1_off    <= 1'b0;
         s1_alloff <= 1'b0;
         s1_note   <= 7'd0;
         s1_semi   <= 4'd0;
         s1_oct    <= 4'd0;
      end else begin
         s1_on     <= dec_on;
         s1_off    <= dec_off;
         s1_alloff <= dec_alloff;
         s1_note   <= msg_d1;
         s1_semi   <= semi;
         s1_oct    <= oct;
      end
   end

   // Half-periods of the lowest octave (notes 0..11) at 50 MHz.
   function automatic logic [21:0] base_sp(input logic [3:0] k);
      case (k)
         4'd0:    base_sp = 22'd3057806;
         4'd1:    base_sp = 22'd2886184;
         4'd2:    base_sp = 22'd2724195;
         4'd3:    base_sp = 22'd2571297;
         4'd4:    base_sp = 22'd2426982;
         4'd5:    base_sp = 22'd2290766;
         4'd6:    base_sp = 22'd2162195;
         4'd7:    base_sp = 22'd2040840;
         4'd8:    base_sp = 22'd1926297;
         4'd9:    base_sp = 22'd1818182;
         4'd10:   base_sp = 22'd1716135;
         default: base_sp = 22'd1619816;
      endcase
   endfunction

   // Note-off matching uses the live note/enable so back-to-back events resolve in order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_en_q <= 1'b0;
         f_sp_q <= 22'd0;
         note_q <= 7'd0;
         evt_q  <= 1'b0;
      end else begin
         evt_q <= 1'b0;
         if (s1_on) begin
            f_en_q <= 1'b1;
            f_sp_q <= base_sp(s1_semi) >> s1_oct;
            note_q <= s1_note;
            evt_q  <= 1'b1;
         end else if (s1_off && f_en_q && (s1_note == note_q)) begin
            f_en_q <= 1'b0;
            evt_q  <= 1'b1;
         end else if (s1_alloff) begin
            f_en_q <= 1'b0;
            evt_q  <= 1'b1;
         end
      end
   end

   assign bus.f_en = f_en_q;
   assign bus.f_sp = f_sp_q;
   assign bus.note = note_q;
   assign bus.evt  = evt_q;
endmodule
